// File: rtl/otf_quotient_convert_if.sv
// otf_quotient_convert_if: digit stream in, corrected quotient out for the on-the-fly converter
interface otf_quotient_convert_if #(parameter int QBITS = 8);
  logic             state0;
  logic [1:0]       q;
  logic             w_sign;
  logic [QBITS-1:0] quotient;
  logic             done;
  logic             busy;
  logic             digit_err;
  modport master (output state0, q, w_sign, input quotient, done, busy, digit_err);
  modport slave  (input state0, q, w_sign, output quotient, done, busy, digit_err);
endinterface

// File: rtl/otf_quotient_convert.sv
// otf_quotient_convert: radix-2 on-the-fly Q/QM conversion with final remainder-sign correction
module otf_quotient_convert #(parameter int QBITS = 8) (
  input  logic clock,
  input  logic reset_n,
  otf_quotient_convert_if.slave bus
);
  localparam int CW = $clog2(QBITS) + 1;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t           st;
  logic [CW-1:0]    cnt;
  logic [QBITS-1:0] qr, qm, q_src, qm_src, qr_n, qm_n;
  logic             pos, neg;
  // QM tracks Q - ulp so a -1 digit just selects QM instead of subtracting
  always_comb begin
    pos    = bus.q == 2'b01;
    neg    = bus.q == 2'b11;
    q_src  = neg ? qm : qr;
    qm_src = pos ? qr : qm;
    qr_n   = {q_src[QBITS-2:0], pos | neg};
    qm_n   = {qm_src[QBITS-2:0], ~(pos | neg)};
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st            <= IDLE;
      qr            <= '0;
      qm            <= '1;
      cnt           <= '0;
      bus.quotient  <= '0;
      bus.done      <= 1'b0;
      bus.busy      <= 1'b0;
      bus.digit_err <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (bus.state0) begin
        st            <= RUN;
        qr            <= '0;
        qm            <= '1;
        cnt           <= '0;
        bus.busy      <= 1'b1;
        bus.digit_err <= 1'b0;
      end else if (st == RUN) begin
        qr  <= qr_n;
        qm  <= qm_n;
        cnt <= cnt + 1'b1;
        if (bus.q == 2'b10) bus.digit_err <= 1'b1;
        if (cnt == CW'(QBITS - 1)) st <= FIX;
      end else if (st == FIX) begin
        bus.quotient <= bus.w_sign ? qm : qr;
        bus.done     <= 1'b1;
        bus.busy     <= 1'b0;
        st           <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_otf_quotient_convert.sv
// tb_otf_quotient_convert: scoreboarded directed vectors for the on-the-fly quotient converter
module tb_otf_quotient_convert;
  localparam logic [1:0] P = 2'b01, Z = 2'b00, M = 2'b11, E = 2'b10;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [7:0] sb[$];
  otf_quotient_convert_if #(.QBITS(8)) bus ();
  otf_quotient_convert #(.QBITS(8)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // quotient comparisons are decoupled from stimulus: expected values wait in sb
  always @(negedge clock) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) check("unexpected_done", 8'd1, 8'd0);
      else check("quotient", bus.quotient, sb.pop_front());
    end
  end
  task automatic start();
    bus.state0 = 1'b1;
    @(posedge clock); #1;
    bus.state0 = 1'b0;
  endtask
  task automatic digits(input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      bus.q = d[2*(7-i) +: 2];
      @(posedge clock); #1;
      check("done_low_in_run", {7'd0, bus.done}, 8'd0);
    end
    bus.q = Z;
  endtask
  task automatic run_conv(input string name, input logic [15:0] d, input logic ws, input logic [7:0] exp);
    sb.push_back(exp);
    start();
    check({name, "_busy"}, {7'd0, bus.busy}, 8'd1);
    digits(d, 8);
    bus.w_sign = ws;
    @(posedge clock); #1;
    check({name, "_done"}, {7'd0, bus.done}, 8'd1);
    bus.w_sign = 1'b0;
    @(posedge clock); #1;
    check({name, "_done_pulse"}, {7'd0, bus.done}, 8'd0);
    check({name, "_busy_end"}, {7'd0, bus.busy}, 8'd0);
  endtask
  initial begin
    bus.state0 = 1'b0;
    bus.q = Z;
    bus.w_sign = 1'b0;
    #12;
    check("rst_quotient", bus.quotient, 8'h00);
    check("rst_flags", {5'd0, bus.done, bus.busy, bus.digit_err}, 8'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    run_conv("t1", {P, P, Z, Z, P, P, P, Z}, 1'b0, 8'hCE);
    run_conv("t2", {P, P, Z, P, Z, M, P, Z}, 1'b1, 8'hCD);
    run_conv("zeros", {Z, Z, Z, Z, Z, Z, Z, Z}, 1'b0, 8'h00);
    run_conv("negs", {M, M, M, M, M, M, M, M}, 1'b0, 8'h01);
    run_conv("poss", {P, P, P, P, P, P, P, P}, 1'b1, 8'hFE);
    check("hold_quotient", bus.quotient, 8'hFE);
    start();
    digits({P, M, P, M, Z, Z, Z, Z}, 4);
    check("abort_busy", {7'd0, bus.busy}, 8'd1);
    run_conv("restart", {P, P, P, P, P, P, P, P}, 1'b0, 8'hFF);
    start();
    check("start_keeps_quotient", bus.quotient, 8'hFF);
    digits({P, P, Z, Z, Z, Z, Z, Z}, 3);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_quotient", bus.quotient, 8'h00);
    check("async_rst_busy", {7'd0, bus.busy}, 8'd0);
    #3 reset_n = 1'b1;
    @(posedge clock); #1;
    check("post_rst_idle", {7'd0, bus.busy}, 8'd0);
    run_conv("after_rst", {P, P, Z, Z, P, P, P, Z}, 1'b0, 8'hCE);
    run_conv("err", {P, P, E, P, Z, Z, Z, P}, 1'b0, 8'hD1);
    check("err_sticky", {7'd0, bus.digit_err}, 8'd1);
    repeat (3) @(posedge clock);
    #1 check("err_held_idle", {7'd0, bus.digit_err}, 8'd1);
    start();
    check("err_cleared", {7'd0, bus.digit_err}, 8'd0);
    digits({Z, Z, Z, Z, Z, Z, Z, Z}, 8);
    @(posedge clock); #1;
    check("final_zero", bus.quotient, 8'h00);
    check("sb_empty", 8'(sb.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
